// File: rtl/univ_shift_register_burst.sv
// Parametrised universal shift register with rotate, arithmetic shift, clock enable and burst-shift engine.
// Optional registered zero flag on o_zero when USR_ZERO_FLAG_EN is defined.
module univ_shift_register_burst #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_en,
   input  logic [2:0]       i_mode,
   input  logic [WIDTH-1:0] i_data_in,
   input  logic             i_serial_in_left,
   input  logic             i_serial_in_right,
   input  logic             i_burst_dir,
   input  logic [AMT_W-1:0] i_shift_amt,
   output logic [WIDTH-1:0] o_data_out,
   output logic             o_serial_out_right,
   output logic             o_serial_out_left,
   output logic             o_busy,
`ifdef USR_ZERO_FLAG_EN
   output logic             o_zero,
`endif
   output logic             o_done
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   typedef enum logic [2:0] {
      MODE_HOLD  = 3'b000,
      MODE_SHR   = 3'b001,
      MODE_SHL   = 3'b010,
      MODE_LOAD  = 3'b011,
      MODE_ROR   = 3'b100,
      MODE_ROL   = 3'b101,
      MODE_ASR   = 3'b110,
      MODE_BURST = 3'b111
   } mode_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_data, w_data_nxt;
   logic [AMT_W-1:0] r_count, w_count_nxt;
   logic             r_dir, w_dir_nxt;
   logic             r_done, w_done_nxt;
   logic [WIDTH-1:0] w_shr, w_shl;

   assign w_shr = {i_serial_in_left, r_data[WIDTH-1:1]};
   assign w_shl = {r_data[WIDTH-2:0], i_serial_in_right};

   always_comb begin
      // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
      w_state_nxt = r_state;
      w_data_nxt  = r_data;
      w_count_nxt = r_count;
      w_dir_nxt   = r_dir;
      w_done_nxt  = 1'b0;
      if (i_en) begin
         case (r_state)
            ST_IDLE: begin
               case (mode_t'(i_mode))
                  MODE_HOLD:  w_data_nxt = r_data;
                  MODE_SHR:   w_data_nxt = w_shr;
                  MODE_SHL:   w_data_nxt = w_shl;
                  MODE_LOAD:  w_data_nxt = i_data_in;
                  MODE_ROR:   w_data_nxt = {r_data[0], r_data[WIDTH-1:1]};
                  MODE_ROL:   w_data_nxt = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                  MODE_ASR:   w_data_nxt = {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                  MODE_BURST: begin
                     w_dir_nxt   = i_burst_dir;
                     w_count_nxt = i_shift_amt;
                     // A zero-length burst completes immediately without entering BUSY.
                     if (i_shift_amt != '0) w_state_nxt = ST_BUSY;
                     else                   w_done_nxt  = 1'b1;
                  end
                  default:    w_data_nxt = r_data;
               endcase
            end
            ST_BUSY: begin
               w_data_nxt  = r_dir ? w_shl : w_shr;
               w_count_nxt = r_count - 1'b1;
               if (r_count == AMT_W'(1)) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_data  <= '0;
         r_count <= '0;
         r_dir   <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_data  <= w_data_nxt;
         r_count <= w_count_nxt;
         r_dir   <= w_dir_nxt;
         r_done  <= w_done_nxt;
      end
   end

`ifdef USR_ZERO_FLAG_EN
   logic r_zero;

   always_ff @(posedge i_clk) begin
      if (i_reset)   r_zero <= 1'b1;
      else if (i_en) r_zero <= (w_data_nxt == '0);
   end

   assign o_zero = r_zero;
`endif

   assign o_data_out         = r_data;
   assign o_serial_out_right = r_data[0];
   assign o_serial_out_left  = r_data[WIDTH-1];
   assign o_busy             = (r_state == ST_BUSY);
   assign o_done             = r_done;

endmodule

// File: tb/tb_univ_shift_register_burst.sv
// Scoreboard bench for univ_shift_register_burst: the stimulus side pushes model predictions,
// and a monitor compares them against the DUT shortly after each rising edge.
module tb_univ_shift_register_burst;
   localparam int W = 8;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         reset, en, sl, sr, dir;
   logic [2:0]   mode;
   logic [W-1:0] din;
   logic [A-1:0] amt;
   logic [W-1:0] data_out;
   logic         so_r, so_l, busy, done;
`ifdef USR_ZERO_FLAG_EN
   logic         zero;
`endif

   univ_shift_register_burst #(.WIDTH(W), .AMT_W(A)) dut (
      .i_clk(clk), .i_reset(reset), .i_en(en), .i_mode(mode), .i_data_in(din),
      .i_serial_in_left(sl), .i_serial_in_right(sr), .i_burst_dir(dir), .i_shift_amt(amt),
      .o_data_out(data_out), .o_serial_out_right(so_r), .o_serial_out_left(so_l),
      .o_busy(busy),
`ifdef USR_ZERO_FLAG_EN
      .o_zero(zero),
`endif
      .o_done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] data;
      logic         busy;
      logic         done;
      string        tag;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Behavioural model: contents, shifts still owed, latched direction, done pulse.
   logic [W-1:0] m_data = '0;
   int           m_rem  = 0;
   logic         m_dir  = 1'b0;
   logic         m_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit e, input bit [2:0] md, input bit [W-1:0] d,
                             input bit l, input bit r, input bit bd, input bit [A-1:0] n);
      if (rst) begin
         m_data = '0; m_rem = 0; m_dir = 1'b0; m_done = 1'b0;
      end else if (!e) begin
         m_done = 1'b0;
      end else if (m_rem > 0) begin
         if (m_dir) m_data = (m_data << 1) | W'(r);
         else       m_data = (m_data >> 1) | (W'(l) << (W-1));
         m_rem  = m_rem - 1;
         m_done = (m_rem == 0);
      end else begin
         m_done = 1'b0;
         case (md)
            3'd1: m_data = (m_data >> 1) | (W'(l) << (W-1));
            3'd2: m_data = (m_data << 1) | W'(r);
            3'd3: m_data = d;
            3'd4: m_data = (m_data >> 1) | (m_data << (W-1));
            3'd5: m_data = (m_data << 1) | (m_data >> (W-1));
            3'd6: m_data = W'($signed(m_data) >>> 1);
            3'd7: begin
               m_dir  = bd;
               m_rem  = int'(n);
               m_done = (n == 0);
            end
            default: ;
         endcase
      end
   endtask

   task automatic step(input string tag, input bit rst, input bit e, input bit [2:0] md,
                       input bit [W-1:0] d = '0, input bit l = 1'b0, input bit r = 1'b0,
                       input bit bd = 1'b0, input bit [A-1:0] n = '0);
      exp_t x;
      @(negedge clk);
      reset = rst; en = e; mode = md; din = d; sl = l; sr = r; dir = bd; amt = n;
      model_edge(rst, e, md, d, l, r, bd, n);
      x.data = m_data; x.busy = (m_rem > 0); x.done = m_done; x.tag = tag;
      q.push_back(x);
   endtask

   // Monitor: one prediction per rising edge, compared 2 time units after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check({e.tag, ".data"}, 32'(data_out), 32'(e.data));
            check({e.tag, ".sor"},  32'(so_r),     32'(e.data[0]));
            check({e.tag, ".sol"},  32'(so_l),     32'(e.data[W-1]));
            check({e.tag, ".busy"}, 32'(busy),     32'(e.busy));
            check({e.tag, ".done"}, 32'(done),     32'(e.done));
`ifdef USR_ZERO_FLAG_EN
            check({e.tag, ".zero"}, 32'(zero),     32'(e.data == '0));
`endif
         end
      end
   end

   initial begin
      reset = 1'b1; en = 1'b0; mode = '0; din = '0; sl = 1'b0; sr = 1'b0; dir = 1'b0; amt = '0;
      step("rst", 1, 0, 3'd0);
      step("rst", 1, 1, 3'd3, 8'hFF);

      // Reset in the middle of a burst.
      step("t1", 0, 1, 3'd3, 8'hA5);
      step("t1", 0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd3);
      step("t1", 0, 1, 3'd0);
      step("t1", 1, 1, 3'd0);
      step("t1", 0, 1, 3'd0);
      step("t1", 0, 1, 3'd1, 8'h00, 1);

      // Arithmetic shift right.
      step("t2", 0, 1, 3'd3, 8'hB4);
      step("t2", 0, 1, 3'd6);
      step("t2", 0, 1, 3'd6);

      // Rotates.
      step("t3", 0, 1, 3'd3, 8'h81);
      step("t3", 0, 1, 3'd5);
      step("t3", 0, 1, 3'd3, 8'h81);
      step("t3", 0, 1, 3'd4);
      step("t3", 0, 1, 3'd2, 8'h00, 0, 1);

      // Three-shift right burst, mode toggled while busy.
      step("t4", 0, 1, 3'd3, 8'hA5);
      step("t4", 0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd3);
      step("t4", 0, 1, 3'd3, 8'hFF);
      step("t4", 0, 1, 3'd5, 8'hFF, 0, 1, 1, 4'd9);
      step("t4", 0, 1, 3'd7, 8'hFF, 0, 0, 1, 4'd2);
      step("t4", 0, 1, 3'd0);

      // Same burst frozen by en=0 after the first shift.
      step("t5", 0, 1, 3'd3, 8'hA5);
      step("t5", 0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd3);
      step("t5", 0, 1, 3'd0);
      step("t5", 0, 0, 3'd3, 8'hFF, 1);
      step("t5", 0, 0, 3'd3, 8'hFF, 1);
      step("t5", 0, 1, 3'd0);
      step("t5", 0, 1, 3'd0);
      step("t5", 0, 1, 3'd0);

      // Zero-length burst, back-to-back left burst, and an over-length burst.
      step("t6", 0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd0);
      step("t6", 0, 1, 3'd7, 8'h00, 0, 1, 1, 4'd2);
      step("t6", 0, 1, 3'd0, 8'h00, 0, 1);
      step("t6", 0, 1, 3'd0, 8'h00, 0, 0);
      step("t6", 0, 1, 3'd7, 8'h00, 0, 0, 1, 4'd0);
      step("t6", 0, 1, 3'd7, 8'h00, 1, 0, 0, 4'd11);
      for (int i = 0; i < 12; i++) step("t6", 0, 1, 3'd0, 8'h00, 1);
      step("t6", 0, 1, 3'd3, 8'h00);
      step("t6", 0, 1, 3'd3, 8'h01);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
              3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 4'($urandom_range(0, 15)));
      end

      step("end", 0, 1, 3'd0);
      repeat (2) @(posedge clk);
      #3;
      check("drain", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
